// File: rtl/fifo_pkt_pkg.sv
// Shared widths, parser state encoding and output-buffer entry layout for the
// length-prefixed FIFO packet reader.
package fifo_pkt_pkg;

    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 3;
    localparam int LEN_W     = 8;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } pkt_entry_t;

endpackage

// File: rtl/pkt_skid_buf.sv
// Small circular output buffer holding {sop, eop, data} entries between the
// packet parser and the downstream valid/ready stream.
module pkt_skid_buf
    import fifo_pkt_pkg::*;
#(
    parameter  int DEPTH = BUF_DEPTH,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             push,
    input  pkt_entry_t       push_entry,
    input  logic             pop,
    output pkt_entry_t       head,
    output logic [OCC_W-1:0] occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pkt_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // NOTE: storage is not reset; occ gates every read of it, so stale contents never escape.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values, independent of block order.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from a registered-read FIFO, strips the length
// header and streams the payload with sop/eop framing over valid/ready.
module fifo_pkt_reader #(
    parameter int BUF_DEPTH = fifo_pkt_pkg::BUF_DEPTH,
    parameter int DATA_W    = fifo_pkt_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_read,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              err_zero_len,
    output logic [15:0]       pkt_cnt,
    output logic              busy
);
    import fifo_pkt_pkg::*;

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] remain_q;
    logic [LEN_W-1:0] remain_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             rd_pend;
    logic             run_q;
    logic             err_d;
    logic             push;
    logic             pop;
    pkt_entry_t       push_entry;
    pkt_entry_t       head;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   inflight;

    // A read is allowed only if the buffer can absorb it plus the byte already in flight;
    // run_q keeps reads off during reset without a combinational path from RSTn.
    assign inflight  = {1'b0, occ} + (OCC_W + 1)'(rd_pend);
    assign fifo_read = run_q & en & ~fifo_empty & (inflight < (OCC_W + 1)'(BUF_DEPTH));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        len_d      = len_q;
        err_d      = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        if (rd_pend) begin
            unique case (state_q)
                HDR: begin
                    if (fifo_rdata == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = LEN_W'(fifo_rdata);
                        remain_d = LEN_W'(fifo_rdata);
                        state_d  = PAY;
                    end
                end
                PAY: begin
                    push            = 1'b1;
                    push_entry.sop  = (remain_q == len_q);
                    push_entry.eop  = (remain_q == LEN_W'(1));
                    push_entry.data = fifo_rdata;
                    remain_d        = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = HDR;
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= HDR;
            remain_q     <= '0;
            len_q        <= '0;
            rd_pend      <= 1'b0;
            run_q        <= 1'b0;
            err_zero_len <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            len_q        <= len_d;
            rd_pend      <= fifo_read;
            run_q        <= 1'b1;
            err_zero_len <= err_d;
            if (pop && head.eop) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

    pkt_skid_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    // Outputs are forced to zero while empty so reset and idle show clean values.
    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? head.data : '0;
    assign m_sop   = m_valid & head.sop;
    assign m_eop   = m_valid & head.eop;
    assign busy    = (state_q == PAY) | rd_pend | m_valid;

endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 SHALL have ports: CLK  in  1  clock, all state on rising edge.
REQ-002 SHALL have ports: RSTn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: en  in  1  permits issuing new FIFO reads.
REQ-004 SHALL have ports: fifo_empty  in  1  FIFO empty flag.
REQ-005 SHALL have ports: fifo_rdata  in  8  FIFO registered read data, valid the cycle after fifo_read.
REQ-006 SHALL have ports: fifo_read  out  1  FIFO pop strobe.
REQ-007 SHALL have ports: m_valid  out  1; m_ready  in  1; m_data  out  8; m_sop  out  1; m_eop  out  1.
REQ-008 SHALL have ports: err_zero_len  out  1  one-cycle pulse; pkt_cnt  out  16  packets delivered; busy  out  1.
REQ-009 SHALL use parameters: BUF_DEPTH, default 3, output buffer entries; DATA_W, default 8, byte width.

Function
REQ-010 SHALL assert fifo_read only when fifo_empty=0, en=1 and (occ + rd_pend) < BUF_DEPTH; occ = buffer count, rd_pend = read issued last cycle.
REQ-011 SHALL never assert fifo_read while fifo_empty=1, because the FIFO advances its pointer on any read.
REQ-012 SHALL register rd_pend <= fifo_read; when rd_pend=1, fifo_rdata SHALL be captured that cycle (one-cycle read latency).
REQ-013 SHALL drive fifo_read from registered state only, with no combinational path from m_ready.
REQ-014 SHALL run a 2-state parser FSM on captured bytes: HDR (reset state) and PAY.
REQ-015 In HDR, captured byte L != 0 SHALL load remain <= L and move to PAY; the header byte SHALL NOT be forwarded.
REQ-016 In HDR, captured byte 0 SHALL pulse err_zero_len for one cycle, be discarded, and stay in HDR.
REQ-017 In PAY, each captured byte SHALL be pushed to the buffer with sop = (remain == L) and eop = (remain == 1), then remain decrements; on eop the FSM SHALL return to HDR.
REQ-018 remain SHALL be 8 bits; L=255 SHALL yield 255 payload bytes with no wrap.
REQ-019 SHALL present the buffer head on m_data/m_sop/m_eop with m_valid = (occ != 0); a transfer occurs when m_valid & m_ready.
REQ-020 m_data/m_sop/m_eop SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 Simultaneous push and pop SHALL leave occ unchanged; BUF_DEPTH accounting SHALL guarantee no buffer overflow.
REQ-022 With m_ready held at 1 and the FIFO non-empty, SHALL sustain one payload byte per cycle after a 2-cycle fill latency.
REQ-023 pkt_cnt SHALL increment on each transfer with m_eop=1 and wrap from 0xFFFF to 0.
REQ-024 en deasserted SHALL stop new reads only; an in-flight byte SHALL still be captured, and the buffer SHALL drain normally.
REQ-025 busy SHALL be 1 when state=PAY, rd_pend=1 or occ != 0.

Reset
REQ-026 RSTn low SHALL immediately clear: state=HDR, remain=0, rd_pend=0, occ=0, pkt_cnt=0, fifo_read=0, m_valid=0, m_sop=0, m_eop=0, m_data=0, err_zero_len=0, busy=0.
REQ-027 Reset mid-packet SHALL discard any in-flight and buffered bytes; after release, the next captured byte is a header.

Structure
REQ-028 Package fifo_pkt_pkg SHALL hold DATA_W, BUF_DEPTH, the HDR/PAY state encoding and the buffer entry layout {sop, eop, data}.
REQ-029 The output buffer SHALL be sub-module pkt_skid_buf (BUF_DEPTH x 10-bit circular buffer with push/pop/occ); all other logic stays in fifo_pkt_reader.

Verification
REQ-030 FIFO holds 03,A1,A2,A3; m_ready=1 -> fifo_read asserted 4 cycles; outputs A1(sop),A2,A3(eop); pkt_cnt=1.
REQ-031 FIFO holds 00,01,55 -> err_zero_len pulses once; single byte 55 with sop=eop=1; pkt_cnt=1.
REQ-032 Header FF plus 255 bytes, m_ready=0 for first 20 cycles -> occ reaches 3; fifo_read never asserts at occ+rd_pend=3; all 255 bytes delivered in order.
REQ-033 FIFO empties mid-packet for 5 cycles -> fifo_read=0 while fifo_empty=1; no duplicate or lost byte; state stays PAY.
REQ-034 en dropped the cycle fifo_read=1 -> the in-flight byte is still delivered and no further reads occur.
REQ-035 RSTn pulsed mid-packet (remain=7) -> all outputs 0; a following 02,B1,B2 is delivered as a fresh packet.
